// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer and dat_mem arbiter between host loader and core
module run_ctrl #(
    parameter int D       = 10,
    parameter int DONE_PC = 381,
    parameter int AW      = 8,
    parameter int CW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic          host_gnt,
    output logic [7:0]    host_rdata,
    output logic          host_rvalid,
    input  logic          core_we,
    input  logic          core_re,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdata,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_rst,
    output logic          pc_en,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] cycles
);
    typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, FAULT} state_t;
    state_t state, nxt;
    logic at_done, at_to, host_own, core_own;
    assign at_done = prog_ctr == D'(DONE_PC);
    assign at_to = cycles == CW'(TIMEOUT - 1);
    assign host_rdata = mem_dout;
    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;
    // next-state: abort beats done, done beats timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE:        nxt = start ? ARM : IDLE;
            ARM:         nxt = abort ? IDLE : RUN;
            RUN:         nxt = abort ? IDLE : at_done ? DONE : at_to ? FAULT : RUN;
            DONE, FAULT: nxt = start ? ARM : state;
            default:     nxt = IDLE;
        endcase
    end
    // run cycle counter: cleared in ARM, saturating count of RUN edges not cut short by abort
    always_ff @(posedge clk or negedge reset)
        if (!reset) cycles <= '0;
        else if (state == ARM) cycles <= '0;
        else if (state == RUN && !abort && cycles != {CW{1'b1}}) cycles <= cycles + 1'b1;
    // decoded outputs and memory ownership, forced idle while reset is low
    always_comb begin
        host_own    = reset && (state == IDLE || state == DONE || state == FAULT);
        core_own    = reset && state == RUN;
        core_rst    = !reset || state == IDLE || state == ARM;
        pc_en       = core_own && !at_done;
        busy        = reset && (state == ARM || state == RUN);
        done        = reset && state == DONE;
        fault       = reset && state == FAULT;
        host_gnt    = host_own && host_req;
        host_rvalid = host_gnt && !host_we;
        mem_wr_en   = host_own ? host_req && host_we : core_own && core_we;
        mem_rd_en   = host_own ? host_req && !host_we : core_own && core_re;
        mem_addr    = core_own ? core_addr : host_addr;
        mem_din     = core_own ? core_wdata : host_wdata;
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboard bench for run_ctrl with straight-line and looping core models
module tb_run_ctrl;
    logic clk = 0, reset = 0, start = 0, start_t = 0, abort = 0;
    logic host_req = 0, host_we = 0, core_we = 0, core_re = 0;
    logic [7:0] host_addr = 0, host_wdata = 0, core_addr = 0, core_wdata = 0;
    logic host_gnt, host_rvalid, mem_wr_en, mem_rd_en, core_rst, pc_en, busy, done, fault;
    logic [7:0] host_rdata, mem_addr, mem_din, mem_dout;
    logic [15:0] cycles;
    logic host_gnt_t, host_rvalid_t, mem_wr_en_t, mem_rd_en_t, core_rst_t, pc_en_t, busy_t, done_t, fault_t;
    logic [7:0] host_rdata_t, mem_addr_t, mem_din_t;
    logic [15:0] cycles_t;
    logic [9:0] pc, pc_t;
    logic [7:0] mem [256];
    logic [7:0] rd_q [$];
    logic [15:0] run_q [$], run_q_t [$];
    logic done_q = 0, fault_q = 0;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    run_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .core_we(core_we), .core_re(core_re), .core_addr(core_addr), .core_wdata(core_wdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .prog_ctr(pc), .core_rst(core_rst), .pc_en(pc_en),
        .busy(busy), .done(done), .fault(fault), .cycles(cycles)
    );

    run_ctrl #(.TIMEOUT(100)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .abort(abort),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt_t), .host_rdata(host_rdata_t), .host_rvalid(host_rvalid_t),
        .core_we(1'b0), .core_re(1'b0), .core_addr(8'h00), .core_wdata(8'h00),
        .mem_wr_en(mem_wr_en_t), .mem_rd_en(mem_rd_en_t), .mem_addr(mem_addr_t), .mem_din(mem_din_t),
        .mem_dout(8'h00), .prog_ctr(pc_t), .core_rst(core_rst_t), .pc_en(pc_en_t),
        .busy(busy_t), .done(done_t), .fault(fault_t), .cycles(cycles_t)
    );

    // core PC models: straight-line ROM and a ten-instruction infinite loop
    always @(posedge clk) begin
        pc <= core_rst ? 10'd0 : pc_en ? pc + 10'd1 : pc;
        pc_t <= core_rst_t ? 10'd0 : pc_en_t ? (pc_t == 10'd9 ? 10'd0 : pc_t + 10'd1) : pc_t;
    end

    // dat_mem model: synchronous write, combinational read
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: host read data and run-completion cycle counts against the queues
    always @(negedge clk) begin
        if (host_rvalid) begin
            if (rd_q.size() == 0) chk("unexpected_rvalid", 1, 0);
            else chk("host_rdata", host_rdata, rd_q.pop_front());
        end
        if (done && !done_q) begin
            if (run_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycles", cycles, run_q.pop_front());
        end
        if (fault_t && !fault_q) begin
            if (run_q_t.size() == 0) chk("unexpected_fault", 1, 0);
            else chk("fault_cycles", cycles_t, run_q_t.pop_front());
        end
        done_q = done;
        fault_q = fault_t;
    end

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
        @(negedge clk);
        chk("wr_gnt", host_gnt, 1);
        chk("wr_no_rvalid", host_rvalid, 0);
        step();
        host_req = 0; host_we = 0;
    endtask

    task automatic host_rd(input logic [7:0] a, input logic [7:0] d);
        host_req = 1; host_we = 0; host_addr = a;
        rd_q.push_back(d);
        @(negedge clk);
        chk("rd_gnt", host_gnt, 1);
        step();
        host_req = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000 && !done; i++) step();
        chk("done_reached", done, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #3;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_status", {busy, done, fault, pc_en}, 0);
        chk("rst_cycles", cycles, 0);
        host_req = 1; host_we = 1;
        #1;
        chk("rst_enables", {host_gnt, host_rvalid, mem_wr_en, mem_rd_en}, 0);
        host_req = 0; host_we = 0;
        step(); reset = 1; step();

        host_wr(8'h10, 8'hA5);
        host_rd(8'h10, 8'hA5);

        start = 1; run_q.push_back(16'd382);
        step(); start = 0;
        chk("arm_state", {busy, core_rst, pc_en}, 3'b110);
        host_req = 1; host_we = 1; host_addr = 8'h30;
        #1;
        chk("arm_no_owner", {host_gnt, mem_wr_en, mem_rd_en}, 0);
        step();
        chk("run_entry", {busy, core_rst, pc_en}, 3'b101);
        chk("run_pc0", pc, 0);
        step(9);
        core_we = 1; core_addr = 8'h20; core_wdata = 8'h5C;
        #1;
        chk("run_host_gnt", host_gnt, 0);
        chk("run_core_wr", {mem_wr_en, mem_addr, mem_din}, {1'b1, 8'h20, 8'h5C});
        step();
        core_we = 0; host_req = 0; host_we = 0;
        wait_done();
        chk("done_cycles_direct", cycles, 382);
        chk("done_pc_en", pc_en, 0);
        step(3);
        chk("pc_frozen", pc, 381);
        chk("cycles_held", cycles, 382);
        host_rd(8'h20, 8'h5C);
        host_rd(8'h30, 8'h00);

        start_t = 1; run_q_t.push_back(16'd100);
        step(); start_t = 0;
        for (int i = 0; i < 300 && !fault_t; i++) step();
        chk("fault_reached", fault_t, 1);
        chk("fault_cycles_direct", cycles_t, 100);
        step(2);
        chk("fault_hold", {fault_t, cycles_t}, {1'b1, 16'd100});
        start_t = 1; step(); start_t = 0;
        chk("rearm_busy", {busy_t, fault_t}, 2'b10);
        step();
        chk("rearm_cleared", cycles_t, 0);
        abort = 1; step(); abort = 0;
        chk("t_abort_idle", {busy_t, core_rst_t}, 2'b01);

        start = 1; step(); start = 0;
        step(5);
        abort = 1; step(); abort = 0;
        chk("abort_idle", {busy, core_rst}, 2'b01);
        chk("abort_cycles", cycles, 4);

        start = 1; step(); start = 0;
        step(21);
        chk("pre_reset_busy", busy, 1);
        core_we = 1; core_addr = 8'h40; core_wdata = 8'h77;
        #1;
        reset = 0;
        #1;
        chk("async_rst_outs", {busy, pc_en, mem_wr_en, host_gnt, core_rst}, 5'b00001);
        chk("async_rst_cycles", cycles, 0);
        step();
        core_we = 0;
        reset = 1;
        step();
        start = 1; run_q.push_back(16'd382);
        step(); start = 0;
        step();
        chk("restart_pc0", {pc, pc_en}, {10'd0, 1'b1});
        wait_done();
        host_rd(8'h40, 8'h00);

        step(2);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("run_q_empty", run_q.size() + run_q_t.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run sequencer and data-memory arbiter for the 9-bit core. It holds the core in reset while idle, starts a program run on a host `start` pulse, and steps the PC until `prog_ctr` reaches `DONE_PC`. It shares the single `dat_mem` port between the host loader (idle/done only) and the core (run only), counts run cycles, and flags a timeout fault. It sits between the testbench/host and `top_level`'s PC, reset and `dat_mem` connections.

## Interface
- `D`, 10: program counter width
- `DONE_PC`, 381: PC value that marks program completion
- `AW`, 8: data memory address width
- `CW`, 16: cycle counter width
- `TIMEOUT`, 4096: maximum RUN cycles before fault (must be ≤ 2^CW−1)

- `clk` in 1: clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; 0 forces all state to reset values immediately
- `start` in 1: begin run; sampled in IDLE/DONE/FAULT only
- `abort` in 1: cancel run; sampled in ARM/RUN only
- `host_req`, `host_we` in 1 each: host memory access request / write select
- `host_addr` in AW; `host_wdata` in 8
- `host_gnt` out 1: host access performed this cycle
- `host_rdata` out 8; `host_rvalid` out 1
- `core_we`, `core_re` in 1 each: core MemWrite / MemtoReg
- `core_addr` in AW; `core_wdata` in 8
- `mem_wr_en`, `mem_rd_en` out 1 each; `mem_addr` out AW; `mem_din` out 8; `mem_dout` in 8
- `prog_ctr` in D: current core PC
- `core_rst` out 1: active-high hold of core PC at 0
- `pc_en` out 1: PC advance enable
- `busy`, `done`, `fault` out 1 each
- `cycles` out CW: RUN cycle count

## Operation
- States: IDLE, ARM, RUN, DONE, FAULT. Reset → IDLE, `cycles`=0.
- IDLE: `start` → ARM.
- ARM: lasts exactly one cycle, clears `cycles` to 0, then → RUN; `abort` → IDLE.
- RUN, priority order:
  - `abort` → IDLE.
  - `prog_ctr`==DONE_PC → DONE.
  - `cycles`==TIMEOUT−1 at the edge → FAULT.
  - Otherwise stay in RUN.
  - Done beats timeout when both occur in the same cycle.
- DONE/FAULT: hold. `start` → ARM, which re-arms and clears `cycles`.
- `cycles`: +1 on every edge spent in RUN, saturating at 2^CW−1. Held in IDLE/DONE/FAULT.
- Decoded outputs (combinational from state):
  - `core_rst`=1 in IDLE and ARM.
  - `pc_en`=1 only in RUN with `prog_ctr`≠DONE_PC, so the PC freezes at DONE_PC.
  - `busy`=ARM|RUN; `done`=DONE; `fault`=FAULT.
- Arbitration:
  - Host owns memory in IDLE/DONE/FAULT: `host_gnt`=`host_req`; `mem_wr_en`=`host_req`&`host_we`; `mem_rd_en`=`host_req`&~`host_we`; address/data from the host.
  - Core owns memory in RUN: `mem_wr_en`=`core_we`, `mem_rd_en`=`core_re`, core address/data.
  - In ARM nobody owns memory: both enables 0, `host_gnt`=0.
  - Host requests during ARM/RUN are not queued. The host holds `host_req` until it sees `host_gnt`.
- Host reads: `host_rdata`=`mem_dout`; `host_rvalid`=`host_gnt`&~`host_we`, same cycle (`dat_mem` read is combinational).
- `start` and `host_req` in the same IDLE cycle: the host access completes that cycle, and the state enters ARM next cycle.

## Timing
- Reset values:
  - Enables: `host_gnt`=0, `host_rvalid`=0, `mem_wr_en`=0, `mem_rd_en`=0, `pc_en`=0.
  - Status: `busy`=0, `done`=0, `fault`=0, `cycles`=0.
  - `core_rst`=1.
- `start` high in cycle t: ARM in t+1 (`core_rst`=1), RUN in t+2 (`core_rst`=0, `pc_en`=1).
- Straight-line program reaching DONE_PC: DONE entered DONE_PC+1 edges after the RUN entry; `cycles`=DONE_PC+1.
- `abort` in cycle t: IDLE at t+1; the core is held in reset from t+1.
- `reset` asserted mid-RUN: all outputs take reset values without waiting for a clock edge. A pending memory write in that cycle is dropped.

## Test plan
- Reset, then host writes 0xA5 to addr 0x10 and reads it back → `host_gnt`=1 both cycles, `host_rdata`=0xA5, `host_rvalid`=1 on the read only.
- `start` pulse with a 382-instruction straight-line ROM → ARM one cycle, RUN 382 cycles, `done`=1, `cycles`=382, `pc_en`=0 with `prog_ctr` frozen at 381.
- Host request during RUN with `core_we`=1, `core_addr`=0x20 → `host_gnt`=0, memory sees the core write; after DONE the host reads 0x20 and gets the core data.
- ROM looping forever, TIMEOUT=100 → `fault`=1 after exactly 100 RUN cycles, `cycles`=100; a later `start` re-arms and clears `cycles`.
- `abort` in the 5th RUN cycle → IDLE next edge, `core_rst`=1, `cycles` holds 4.
- `reset` low in the middle of a run with `start` re-asserted afterwards → outputs immediately at reset values, run restarts cleanly from PC 0.
